keypad_responder: RTL

KEYPAD_RESPONDER -- requirements
Module: keypad_responder

---
 rtl/keypad_responder.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/keypad_responder.sv
// keypad_responder
//   Emulates a human pressing a key on a row/column scanned matrix keypad.
//   A request selects a key (row = key[3:2], col = key[1:0]) and a hold time
//   in ticks. While the virtual contact is closed, the selected column line is
//   pulled low whenever the scanner drives the selected row low. Each press is
//   followed by a mandatory released gap before the next request is accepted.
//
// Parameters
//   TICK_DIV       clock cycles per hold tick
//   RELEASE_TICKS  released gap after every press, in ticks
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   fila       row drive from the scanner, active-low
//   columna    column return to the scanner, active-low, registered
//   req_valid  request strobe (accepted only while req_ready)
//   req_key    key code, 0..15 valid, 16..31 rejected with err
//   req_hold   press duration in ticks (0 behaves as 1)
//   cancel     abort the current press (jumps to the release gap)
//   req_ready  high in IDLE only
//   busy       high whenever not in IDLE
//   done       one-cycle pulse on the last release cycle
//   err        one-cycle pulse when an invalid key is offered in IDLE
//
// Configuration
//   KEYPAD_BOUNCE_EN  when defined, each press starts with a 4-tick contact
//                     bounce (closed, open, closed, open) before the hold.

module keypad_responder #(
  parameter int TICK_DIV      = 25000,
  parameter int RELEASE_TICKS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] fila,
  output logic [3:0] columna,
  input  logic       req_valid,
  input  logic [4:0] req_key,
  input  logic [7:0] req_hold,
  input  logic       cancel,
  output logic       req_ready,
  output logic       busy,
  output logic       done,
  output logic       err
);

  // 21 bits cover a prescaler up to 2^20; 16 bits cover hold (255) and the
  // release gap without wrapping.
  localparam logic [20:0] PRESC_LAST   = 21'(TICK_DIV - 1);
  localparam logic [15:0] RELEASE_LAST = 16'(RELEASE_TICKS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS,
    S_RELEASE
`ifdef KEYPAD_BOUNCE_EN
    , S_BOUNCE
`endif
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [20:0] presc_q;
  logic [15:0] tick_q;
  logic [3:0]  key_q;
  logic [7:0]  hold_q;

  logic tick_end;
  logic press_end;
  logic release_end;
  logic accept;
  logic contact;

  // A tick completes when the prescaler reaches its last count; the state
  // ends on the final cycle of its final tick.
  assign tick_end    = (presc_q == PRESC_LAST);
  assign press_end   = tick_end && (tick_q == {8'd0, hold_q - 8'd1});
  assign release_end = tick_end && (tick_q == RELEASE_LAST);
  assign accept      = (state_q == S_IDLE) && req_valid && !req_key[4];

  // State register plus the tick prescaler and tick counter. Both counters
  // restart from zero whenever the state changes, so every state times
  // itself from a clean start. The key and hold are captured on acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      tick_q  <= '0;
      key_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q || state_q == S_IDLE) begin
        presc_q <= '0;
        tick_q  <= '0;
      end else if (tick_end) begin
        presc_q <= '0;
        tick_q  <= tick_q + 16'd1;
      end else begin
        presc_q <= presc_q + 21'd1;
      end
      if (accept) begin
        key_q  <= req_key[3:0];
        hold_q <= (req_hold == 8'd0) ? 8'd1 : req_hold;
      end
    end
  end

  // Next-state logic. Cancel only matters while the contact phase is in
  // progress; the release gap always runs to completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
`ifdef KEYPAD_BOUNCE_EN
          state_d = S_BOUNCE;
`else
          state_d = S_PRESS;
`endif
        end
      end
`ifdef KEYPAD_BOUNCE_EN
      S_BOUNCE: begin
        if (cancel) begin
          state_d = S_RELEASE;
        end else if (tick_end && tick_q == 16'd3) begin
          state_d = S_PRESS;
        end
      end
`endif
      S_PRESS: begin
        if (cancel || press_end) begin
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (release_end) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode. The bounce pattern closes the contact on even ticks.
  always_comb begin
    req_ready = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_RELEASE) && release_end;
    err       = (state_q == S_IDLE) && req_valid && req_key[4];
    contact   = (state_q == S_PRESS);
`ifdef KEYPAD_BOUNCE_EN
    if (state_q == S_BOUNCE && !tick_q[0]) begin
      contact = 1'b1;
    end
`endif
  end

  // Column return, registered one cycle behind fila. A sampled cancel opens
  // the contact immediately so the column releases on the very next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      columna <= 4'hF;
    end else if (contact && !cancel && !fila[key_q[3:2]]) begin
      columna <= ~(4'b0001 << key_q[1:0]);
    end else begin
      columna <= 4'hF;
    end
  end

endmodule
